// File: rtl/baud_detect_pkg.sv
// Shared constants for the baud-rate detector: FSM state encoding and the
// shift ratios that turn the 8-bit-period measurement into period and half
// period values.
`ifndef BAUD_DETECT_PKG_SV
`define BAUD_DETECT_PKG_SV

package baud_detect_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_FALL = 2'd1,
    MEASURE   = 2'd2,
    LOCKED    = 2'd3
  } state_t;

  // The measured span covers 8 bit periods, so >>3 gives one period and
  // >>4 gives half a period; both are rounded to nearest.
  localparam int PERIOD_SHIFT = 3;
  localparam int HALF_SHIFT   = 4;

  // Falling edges in one 0x55 sync character (start bit plus four data lows).
  localparam int SYNC_FALLS = 5;

endpackage

`endif

// File: rtl/baud_detect_sync_fall.sv
// Two-flop synchronizer for the asynchronous serial line plus a falling
// edge detector on the synchronized value. All flops reset to the idle
// (high) level so a line that is already idle produces no spurious fall.
module sync_fall (
  input  logic clock,
  input  logic reset,
  input  logic rx,
  output logic rx_sync,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // Synchronizer chain plus one extra stage remembering the last synced level
  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= rx;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rx_sync = sync;
  assign fall    = prev & ~sync;

endmodule

// File: rtl/baud_detect.sv
// Auto-baud detector: measures the span between the first and fifth falling
// edge of a 0x55 sync character (8 bit periods) and publishes the bit period
// and half bit period, then holds them locked until restart_i.
// Optional feature: define BAUD_DETECT_CHECK_EN to also reject characters
// whose fall-to-fall intervals deviate from the first interval by >25%.
module baud_detect
  import baud_detect_pkg::*;
#(
  parameter int W   = 16,
  parameter int MIN = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         restart_i,
  input  logic         rx_i,
  output logic [W-1:0] period_o,
  output logic [W-1:0] half_o,
  output logic         valid_o,
  output logic         locked_o,
  output logic         error_o
);

  localparam logic [W-1:0] CNT_MAX      = {W{1'b1}};
  localparam logic [W:0]   MIN_INTERVAL = (W+1)'(2 * MIN);
  localparam logic [W:0]   PERIOD_ROUND = (W+1)'(1 << (PERIOD_SHIFT - 1));
  localparam logic [W:0]   HALF_ROUND   = (W+1)'(1 << (HALF_SHIFT - 1));
  localparam logic [2:0]   LAST_EDGE    = 3'(SYNC_FALLS - 1);

  state_t       state;
  state_t       state_next;
  logic         rx_sync;
  logic         fall;
  logic [W-1:0] counter;
  logic [W-1:0] counter_next;
  logic [W-1:0] last_fall;
  logic [W-1:0] last_fall_next;
  logic [W-1:0] interval;
  logic [2:0]   edge_cnt;
  logic [2:0]   edge_cnt_next;
  logic [W:0]   period_wide;
  logic [W:0]   half_wide;
  logic         valid_next;
  logic         error_next;
  logic         locked_next;
  logic         publish;
  logic         ratio_bad;
  logic         bad_interval;

  sync_fall u_sync_fall (
    .clock   (clock),
    .reset   (reset),
    .rx      (rx_i),
    .rx_sync (rx_sync),
    .fall    (fall)
  );

  // counter holds clocks since edge 1, so the distance to the previous edge
  // is a plain subtraction of the counter value latched at that edge
  assign interval = counter - last_fall;

`ifdef BAUD_DETECT_CHECK_EN
  logic [W-1:0] first_interval;
  logic [W-1:0] interval_diff;

  assign interval_diff = (interval > first_interval) ? (interval - first_interval)
                                                     : (first_interval - interval);
  assign ratio_bad     = (edge_cnt >= 3'd2) && (interval_diff > (first_interval >> 2));

  // Remember interval 1 as the reference for the later intervals
  always_ff @(posedge clock) begin
    if (reset) begin
      first_interval <= '0;
    end else if (state == MEASURE && fall && edge_cnt == 3'd1) begin
      first_interval <= interval;
    end
  end
`else
  assign ratio_bad = 1'b0;
`endif

  assign bad_interval = ({1'b0, interval} < MIN_INTERVAL) || ratio_bad;

  assign period_wide = ({1'b0, counter} + PERIOD_ROUND) >> PERIOD_SHIFT;
  assign half_wide   = ({1'b0, counter} + HALF_ROUND) >> HALF_SHIFT;

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, measurement bookkeeping and next output values; restart wins
  always_comb begin
    state_next     = state;
    counter_next   = counter;
    last_fall_next = last_fall;
    edge_cnt_next  = edge_cnt;
    valid_next     = 1'b0;
    error_next     = 1'b0;
    locked_next    = locked_o;
    publish        = 1'b0;

    case (state)
      IDLE: begin
        if (rx_sync) begin
          state_next = WAIT_FALL;
        end
      end
      WAIT_FALL: begin
        if (fall) begin
          state_next     = MEASURE;
          counter_next   = W'(1);
          last_fall_next = '0;
          edge_cnt_next  = 3'd1;
        end
      end
      MEASURE: begin
        if (counter == CNT_MAX) begin
          error_next = 1'b1;
          state_next = IDLE;
        end else begin
          counter_next = counter + W'(1);
          if (fall) begin
            if (bad_interval) begin
              error_next = 1'b1;
              state_next = IDLE;
            end else if (edge_cnt == LAST_EDGE) begin
              valid_next  = 1'b1;
              locked_next = 1'b1;
              publish     = 1'b1;
              state_next  = LOCKED;
            end else begin
              edge_cnt_next  = edge_cnt + 3'd1;
              last_fall_next = counter;
            end
          end
        end
      end
      LOCKED: begin
        state_next = LOCKED;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (restart_i) begin
      state_next  = IDLE;
      valid_next  = 1'b0;
      error_next  = 1'b0;
      locked_next = 1'b0;
      publish     = 1'b0;
    end
  end

  // Measurement registers and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      counter   <= '0;
      last_fall <= '0;
      edge_cnt  <= '0;
      valid_o   <= 1'b0;
      error_o   <= 1'b0;
      locked_o  <= 1'b0;
      period_o  <= '0;
      half_o    <= '0;
    end else begin
      counter   <= counter_next;
      last_fall <= last_fall_next;
      edge_cnt  <= edge_cnt_next;
      valid_o   <= valid_next;
      error_o   <= error_next;
      locked_o  <= locked_next;
      if (publish) begin
        period_o <= period_wide[W-1:0];
        half_o   <= half_wide[W-1:0];
      end
    end
  end

endmodule

// File: doc/baud_detect.md
BAUD_DETECT -- requirements
Module: baud_detect

Interface
REQ-001 SHALL have parameter W, default 16: measurement counter width; all count and divisor outputs are W bits.
REQ-002 SHALL have parameter MIN, default 4: minimum legal bit period in clocks.
REQ-003 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port clock, input, 1 bit: clock; all state changes on its rising edge.
REQ-005 SHALL have port restart_i, input, 1 bit: single-cycle pulse that drops lock and re-arms detection.
REQ-006 SHALL have port rx_i, input, 1 bit: asynchronous serial line; idles high.
REQ-007 SHALL have port period_o, output, W bits: detected bit period in clocks.
REQ-008 SHALL have port half_o, output, W bits: half bit period in clocks, directly usable as a clock_div DIV value.
REQ-009 SHALL have port valid_o, output, 1 bit: one-cycle pulse when a new measurement is published.
REQ-010 SHALL have port locked_o, output, 1 bit: level; a valid measurement is held.
REQ-011 SHALL have port error_o, output, 1 bit: one-cycle pulse when a measurement is aborted.

Function
REQ-012 SHALL pass rx_i through a 2-flop synchronizer; a fall SHALL be detected in the cycle where the synchronized value is 0 and its previous value was 1.
REQ-013 SHALL implement states IDLE, WAIT_FALL, MEASURE, LOCKED.
- IDLE -> WAIT_FALL when synchronized rx = 1.
- WAIT_FALL -> MEASURE on a fall (edge 1 = start bit).
- MEASURE -> LOCKED on edge 5.
- MEASURE -> IDLE on error.
- LOCKED holds and ignores rx until restart_i.
REQ-014 SHALL measure the sync character 0x55 (LSB first), whose falls occur at bit times 0, 2, 4, 6 and 8; count = clock-cycle distance from edge 1 to edge 5, i.e. 8 bit periods.
REQ-015 SHALL publish period_o = (count + 4) >> 3 and half_o = (count + 8) >> 4, computed at W+1 bits and truncated to W bits.
REQ-016 SHALL assert valid_o and locked_o, and update period_o and half_o, in the cycle after edge 5 is detected.
REQ-017 SHALL hold period_o and half_o stable while locked_o = 1.
REQ-018 SHALL flag any fall-to-fall interval shorter than 2*MIN clocks as an error: error_o pulses in the following cycle and the FSM returns to IDLE.
REQ-019 SHALL treat the counter reaching 2^W-1 in MEASURE as a timeout: error_o pulses and the FSM returns to IDLE; the counter never wraps.
REQ-020 SHALL, on restart_i in any state, clear locked_o, go to IDLE next cycle and leave period_o and half_o unchanged; restart_i SHALL take priority over a simultaneous edge 5 or error, and neither valid_o nor error_o SHALL be asserted in that cycle.
REQ-021 SHALL assert valid_o and error_o mutually exclusively.

Reset
REQ-022 SHALL, on reset, set the state to IDLE, all outputs to 0, counter and edge count to 0, and both synchronizer flops to 1; reset mid-MEASURE SHALL abandon the measurement without asserting valid_o or error_o.

Configuration
REQ-023 SHALL, with BAUD_DETECT_CHECK_EN defined, compare each fall-to-fall interval 2..4 against interval 1 and flag an error per REQ-018 if any deviates by more than interval1 >> 2 (±25%).
REQ-024 SHALL, without BAUD_DETECT_CHECK_EN, perform only the MIN and timeout checks.

Structure
REQ-025 SHALL take the state encodings and the ratio constants (shift 3 for period, shift 4 for half) from the shared clock header, guarded by an include guard.
REQ-026 SHALL instantiate one sub-module, sync_fall, containing the 2-flop synchronizer and the fall detector.

Verification
REQ-027 SHALL cover: W=16, 0x55 at 217 clocks/bit -> count 1736, period_o = 217, half_o = 109, one valid_o pulse, locked_o = 1.
REQ-028 SHALL cover: 0x55 at 13 clocks/bit -> period_o = 13, half_o = 7; a second 0x55 while locked -> outputs unchanged, no valid_o.
REQ-029 SHALL cover: MIN=4, 0x55 at 2 clocks/bit -> error_o at edge 2, no valid_o, FSM back in IDLE.
REQ-030 SHALL cover: W=12, single fall then rx held low -> error_o after 4095 counts, locked_o = 0.
REQ-031 SHALL cover: 0x55 at 100 clocks/bit with interval 3 stretched to 300 -> error_o with BAUD_DETECT_CHECK_EN; without it, valid_o with period_o = 113.
REQ-032 SHALL cover: restart_i and reset each asserted mid-MEASURE -> no valid_o and no error_o; a subsequent 0x55 at 50 clocks/bit -> period_o = 50.
